// File: rtl/result_ram_ctrl.sv
// result_ram_ctrl
//   Write-back sequencer and port arbiter for the NPU result RAM (single port,
//   synchronous write, combinational read). Result beats of LANES words from
//   the PE array are serialized into consecutive RAM words starting at a
//   programmed base address. A host read-out path shares the RAM port, and
//   the host can never be starved.
//
// Ports
//   clk, rst_n               system clock (rising edge), async active-low reset
//   start                    launches a job (ignored unless IDLE)
//   base_addr, count         job base address and word count, sampled on start
//   in_valid/in_ready/in_data  PE beat handshake; lane 0 in the low bits
//   host_rd_req/addr         host read request, held until ack
//   host_rd_ack/data         one-cycle ack with registered read data
//   busy, done               job active / one-cycle end-of-job pulse
//   ram_we/addr/din/dout     RAM port
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; host reads served immediately
// RUN   | accepting beats and writing words, busy=1
// DONE  | one-cycle done pulse, then back to IDLE
module result_ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    host_rd_req,
  input  logic [ADDR_W-1:0]       host_rd_addr,
  output logic                    host_rd_ack,
  output logic [DATA_W-1:0]       host_rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_din,
  input  logic [DATA_W-1:0]       ram_dout
);

  localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] lane_buf [LANES];
  logic [LANE_W-1:0] lane;
  logic              buf_full;
  logic              host_denied;
  logic [ADDR_W-1:0] last_addr;

  logic [ADDR_W:0]   count_clamped;
  logic              job_start;
  logic              beat_take;
  logic              grant_host;
  logic              grant_wr;
  logic              last_write;

  always_comb begin
    count_clamped = (count > DEPTH_C) ? DEPTH_C : count;
    job_start     = (state == IDLE) && start;
    // A pending write normally owns the port; a host request that lost
    // last cycle takes it this cycle, bounding host latency to two cycles.
    grant_host    = host_rd_req && (!buf_full || host_denied);
    grant_wr      = buf_full && !grant_host;
    in_ready      = (state == RUN) && !buf_full && (remaining != '0);
    beat_take     = in_valid && in_ready;
    last_write    = grant_wr && (remaining == ONE_CNT);
  end

  always_comb begin
    ram_we  = grant_wr;
    ram_din = '0;
    if (grant_wr) begin
      ram_addr = wr_ptr;
      ram_din  = lane_buf[lane];
    end else if (grant_host) begin
      ram_addr = host_rd_addr;
    end else begin
      ram_addr = last_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (count_clamped != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_write) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      remaining <= '0;
      lane      <= '0;
      buf_full  <= 1'b0;
    end else begin
      if (job_start) begin
        wr_ptr    <= base_addr;
        remaining <= count_clamped;
        lane      <= '0;
        buf_full  <= 1'b0;
      end else if (beat_take) begin
        lane     <= '0;
        buf_full <= 1'b1;
      end else if (grant_wr) begin
        // DEPTH is a power of two, so the natural wrap gives modulo DEPTH.
        wr_ptr    <= wr_ptr + ADDR_W'(1);
        remaining <= remaining - ONE_CNT;
        lane      <= lane + LANE_W'(1);
        // Remaining lanes of a partial final beat are simply dropped.
        if ((lane == LAST_LANE) || (remaining == ONE_CNT)) begin
          buf_full <= 1'b0;
        end
      end
    end
  end

  // Payload storage needs no reset: buf_full gates every use of it.
  always_ff @(posedge clk) begin
    if (beat_take) begin
      for (int i = 0; i < LANES; i++) begin
        lane_buf[i] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_denied  <= 1'b0;
      host_rd_ack  <= 1'b0;
      host_rd_data <= '0;
      last_addr    <= '0;
    end else begin
      host_denied <= host_rd_req && !grant_host;
      host_rd_ack <= grant_host;
      if (grant_host) begin
        host_rd_data <= ram_dout;
      end
      if (grant_wr || grant_host) begin
        last_addr <= ram_addr;
      end
    end
  end

endmodule

// File: tb/tb_result_ram_ctrl.sv
module tb_result_ram_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int LANES  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [ADDR_W:0]         count = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data = '0;
  logic                    host_rd_req = 1'b0;
  logic [ADDR_W-1:0]       host_rd_addr = '0;
  logic                    host_rd_ack;
  logic [DATA_W-1:0]       host_rd_data;
  logic                    busy;
  logic                    done;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_din;
  logic [DATA_W-1:0]       ram_dout;

  result_ram_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LANES(LANES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
    .host_rd_ack(host_rd_ack), .host_rd_data(host_rd_data),
    .busy(busy), .done(done), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  logic [ADDR_W+DATA_W-1:0] wr_q [$];
  logic [DATA_W-1:0]        rd_q [$];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int beat_cnt = 0;
  int last_we_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_q.push_back({a, d});
  endtask

  function automatic logic [LANES*DATA_W-1:0] mk_beat(input logic [DATA_W-1:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  // Scoreboard monitor: every RAM write and every host ack is matched
  // against the expected stream queued by the stimulus.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] ew;
    logic [DATA_W-1:0]        er;
    if (ram_we) begin
      wr_cnt++;
      last_we_cyc = cyc;
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", ram_addr, ram_din);
      end else begin
        ew = wr_q.pop_front();
        chk("write_addr", ram_addr, ew[ADDR_W+DATA_W-1:DATA_W]);
        chk("write_data", ram_din, ew[DATA_W-1:0]);
      end
    end
    if (in_valid && in_ready) beat_cnt++;
    if (host_rd_ack) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got data 0x%0h, expected no ack", host_rd_data);
      end else begin
        er = rd_q.pop_front();
        chk("host_rd_data", host_rd_data, er);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c, output int s);
    start = 1'b1;
    base_addr = b;
    count = c;
    s = cyc;
    sync();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [LANES*DATA_W-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      sync();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no in_ready within %0d cycles, expected handshake", n);
    end
  endtask

  task automatic wait_done(output int dc, output bit rdy);
    dc = -1;
    rdy = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (in_ready) rdy = 1'b1;
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done pulse, expected one");
    end
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input int exp_lat);
    int r;
    int lat = -1;
    rd_q.push_back(exp);
    host_rd_req = 1'b1;
    host_rd_addr = a;
    r = cyc;
    for (int n = 0; n < 10; n++) begin
      sync();
      if (host_rd_ack) begin
        lat = cyc - r;
        break;
      end
    end
    host_rd_req = 1'b0;
    chk("host_latency", lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, dc, w0, b0, k, first_we, busy_seen;
    bit rdy;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_host_rd_data", host_rd_data, 0);
    rst_n = 1'b1;
    sync();

    // 1: four words from base 0, one word per cycle.
    w0 = wr_cnt;
    push_wr(6'd0, 32'h11111111);
    push_wr(6'd1, 32'h22222222);
    push_wr(6'd2, 32'h33333333);
    push_wr(6'd3, 32'h44444444);
    do_start(6'd0, 7'd4, s);
    chk("t1_busy_run", busy, 1);
    send_beat({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    wait_done(dc, rdy);
    chk("t1_done_cycle", dc, s + 6);
    chk("t1_last_write_cycle", last_we_cyc, s + 5);
    chk("t1_write_count", wr_cnt - w0, 4);
    sync();
    chk("t1_busy_after", busy, 0);
    chk("t1_done_single", done, 0);

    // 2+3: wrap at 63, partial last beat, host read stalls one write.
    w0 = wr_cnt;
    b0 = beat_cnt;
    push_wr(6'd62, 32'hA0);
    push_wr(6'd63, 32'hA1);
    push_wr(6'd0,  32'hA2);
    push_wr(6'd1,  32'hA3);
    push_wr(6'd2,  32'hB0);
    push_wr(6'd3,  32'hB1);
    first_we = -1;
    do_start(6'd62, 7'd6, s);
    fork
      begin
        send_beat(mk_beat(32'hA0));
        send_beat(mk_beat(32'hB0));
        in_valid = 1'b1;
        in_data = {4{32'hEEEEEEEE}};
      end
      begin
        int lat = -1;
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          if (ram_we) begin
            first_we = cyc;
            break;
          end
        end
        rd_q.push_back(32'hA0);
        host_rd_req = 1'b1;
        host_rd_addr = 6'd62;
        for (int n = 0; n < 10; n++) begin
          sync();
          if (host_rd_ack) begin
            lat = cyc - first_we;
            break;
          end
        end
        host_rd_req = 1'b0;
        chk("t3_host_latency", lat, 2);
      end
    join
    wait_done(dc, rdy);
    in_valid = 1'b0;
    chk("t2_first_write_cycle", first_we, s + 2);
    chk("t3_write_span", last_we_cyc - first_we, 7);
    chk("t2_done_cycle", dc, s + 10);
    chk("t2_write_count", wr_cnt - w0, 6);
    chk("t2_beat_count", beat_cnt - b0, 2);
    chk("t2_in_ready_after_last_beat", rdy, 0);
    sync();

    // 4: count=0 finishes immediately without touching the RAM.
    w0 = wr_cnt;
    b0 = beat_cnt;
    in_valid = 1'b1;
    in_data = {4{32'hDEADBEEF}};
    do_start(6'd7, 7'd0, s);
    wait_done(dc, rdy);
    in_valid = 1'b0;
    chk("t4_done_cycle", dc, s + 1);
    chk("t4_in_ready", rdy, 0);
    chk("t4_write_count", wr_cnt - w0, 0);
    chk("t4_beat_count", beat_cnt - b0, 0);
    sync();

    // 5: reset after two of four writes aborts the job.
    w0 = wr_cnt;
    push_wr(6'd0, 32'hC0);
    push_wr(6'd1, 32'hC1);
    do_start(6'd0, 7'd4, s);
    send_beat(mk_beat(32'hC0));
    k = 0;
    for (int n = 0; n < 20 && k < 2; n++) begin
      @(negedge clk);
      if (ram_we) k++;
    end
    sync();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_ack", host_rd_ack, 0);
    chk("t5_rst_host_rd_data", host_rd_data, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_ram_we", ram_we, 0);
    chk("t5_rst_ram_addr", ram_addr, 0);
    chk("t5_rst_ram_din", ram_din, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_in_ready", in_ready, 0);
    chk("t5_write_count", wr_cnt - w0, 2);
    host_read(6'd3, 32'hB1, 1);
    sync();
    host_read(6'd2, 32'hB0, 1);
    sync();
    host_read(6'd1, 32'hC1, 1);
    sync();

    // 6: start while RUN and while DONE is ignored.
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) push_wr(6'(10 + i), 32'hD0 + 32'(i));
    start = 1'b1;
    base_addr = 6'd10;
    count = 7'd4;
    s = cyc;
    sync();
    base_addr = 6'd40;
    count = 7'd2;
    sync();
    start = 1'b0;
    chk("t6_busy_run", busy, 1);
    send_beat(mk_beat(32'hD0));
    wait_done(dc, rdy);
    start = 1'b1;
    base_addr = 6'd20;
    count = 7'd3;
    sync();
    start = 1'b0;
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    chk("t6_done_cycle", dc, s + 7);
    chk("t6_write_count", wr_cnt - w0, 4);
    chk("t6_start_in_done_ignored", busy_seen, 0);
    sync();
    host_read(6'd12, 32'hD2, 1);
    sync();

    // count above DEPTH clamps to 64 words, wrapping the full RAM.
    w0 = wr_cnt;
    b0 = beat_cnt;
    for (int i = 0; i < 64; i++) push_wr(6'((5 + i) % 64), 32'h100 + 32'(i));
    do_start(6'd5, 7'd100, s);
    for (int b = 0; b < 16; b++) send_beat(mk_beat(32'h100 + 32'(4 * b)));
    wait_done(dc, rdy);
    chk("t7_done_cycle", dc, s + 81);
    chk("t7_write_count", wr_cnt - w0, 64);
    chk("t7_beat_count", beat_cnt - b0, 16);
    sync();
    host_read(6'd4, 32'h13F, 1);
    sync();
    host_read(6'd5, 32'h100, 1);
    repeat (3) sync();

    chk("write_queue_empty", wr_q.size(), 0);
    chk("read_queue_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
